// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from imem and
// holds it for decode. Optional perf counters are enabled with IFU_PERF_EN.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
`ifdef IFU_PERF_EN
    ,
    output logic [63:0] perf_fetch_cnt,
    output logic [63:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        kill_q;
    logic        req_valid_q;
    logic        inst_valid_q;
    logic        misalign_q;

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign misalign_err   = misalign_q;

    // Next PC: a redirect always beats the sequential advance on consume.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if ((state_q == S_HOLD) && inst_ready) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end
    end

    // Fetch FSM with its registered outputs and the stale-fetch kill flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            kill_q       <= 1'b0;
            req_valid_q  <= 1'b1;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misalign_q <= 1'b1;
            end
            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_q     <= S_WAIT;
                        req_valid_q <= 1'b0;
                        // Accepted request targets the old PC if a redirect lands now.
                        kill_q      <= redirect_valid;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill_q || redirect_valid) begin
                            state_q     <= S_REQ;
                            req_valid_q <= 1'b1;
                            kill_q      <= 1'b0;
                        end else begin
                            inst_q       <= imem_rdata;
                            inst_pc_q    <= pc_q;
                            state_q      <= S_HOLD;
                            inst_valid_q <= 1'b1;
                        end
                    end else if (redirect_valid) begin
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_valid || inst_ready) begin
                        state_q      <= S_REQ;
                        inst_valid_q <= 1'b0;
                        req_valid_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_REQ;
                    req_valid_q  <= 1'b1;
                    inst_valid_q <= 1'b0;
                    kill_q       <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFU_PERF_EN
    // Consumed-instruction and stall-cycle counters, wrapping at 2^64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 64'd0;
            perf_stall_cnt <= 64'd0;
        end else begin
            if (inst_valid_q && inst_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            end
            if ((state_q == S_WAIT) || ((state_q == S_HOLD) && !inst_ready)) begin
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios followed by a randomized run
// against a PC/stream reference model and a variable-latency memory model.
module tb_ifu;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        misalign_err;
`ifdef IFU_PERF_EN
    logic [63:0] perf_fetch_cnt;
    logic [63:0] perf_stall_cnt;
`endif

    ifu #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
        .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .misalign_err(misalign_err)
`ifdef IFU_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Reference model: PC advances by 4 per consumed word, jumps on redirect.
    logic [31:0] exp_pc;
    logic        mis_exp;
    logic        hold_prev;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    logic        chk_data = 1'b0;

    // Memory model: one outstanding fetch, data derived from its address.
    logic        pending;
    logic [31:0] paddr;
    int          pcnt;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_1E69;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_rdata = 32'd0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        exp_pc = RST_PC; mis_exp = 1'b0; hold_prev = 1'b0; pending = 1'b0; pcnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
`ifdef IFU_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt[31:0] | perf_fetch_cnt[63:32], 32'd0);
        chk("rst_perf_stall", perf_stall_cnt[31:0] | perf_stall_cnt[63:32], 32'd0);
`endif
    endtask

    // One cycle: drive inputs after the falling edge, check, advance the model.
    task automatic step(input logic rr, input logic rv, input logic [31:0] rd,
                        input logic ir, input logic dv, input logic [31:0] dpc);
        @(negedge clk);
        imem_req_ready = rr; imem_resp_valid = rv; imem_rdata = rd;
        inst_ready = ir; redirect_valid = dv; redirect_pc = dpc;
        #1;
        if (hold_prev) begin
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, hold_inst);
            chk("hold_pc", inst_pc, hold_pc);
        end
        if (imem_req_valid) chk("req_addr", imem_addr, exp_pc);
        if (inst_valid && ir) begin
            chk("consume_pc", inst_pc, exp_pc);
            if (chk_data) chk("consume_data", inst, memf(inst_pc));
        end
        chk("misalign", {31'd0, misalign_err}, {31'd0, mis_exp});
        hold_prev = inst_valid && !ir && !dv;
        hold_inst = inst;
        hold_pc   = inst_pc;
        if (inst_valid && ir) exp_pc = exp_pc + 32'd4;
        if (dv) begin
            exp_pc = {dpc[31:2], 2'b00};
            if (dpc[1:0] != 2'b00) mis_exp = 1'b1;
        end
    endtask

    task automatic rand_cycle();
        logic        rr, rv, ir, dv, p_before;
        logic [31:0] dpc;
        p_before = pending;
        rv  = pending && (pcnt == 0);
        rr  = ($urandom_range(0, 3) != 0);
        ir  = ($urandom_range(0, 2) != 0);
        dv  = ($urandom_range(0, 7) == 0);
        dpc = 32'h8000_0000 | ($urandom & 32'h0000_0FFC);
        if ($urandom_range(0, 9) == 0) dpc[1:0] = 2'($urandom_range(1, 3));
        step(rr, rv, rv ? memf(paddr) : 32'd0, ir, dv, dpc);
        if (p_before) chk("one_outstanding", {31'd0, imem_req_valid}, 32'd0);
        if (rv) pending = 1'b0;
        else if (pending && pcnt > 0) pcnt--;
        if (imem_req_valid && rr) begin
            pending = 1'b1;
            paddr   = imem_addr;
            pcnt    = $urandom_range(0, 2);
        end
    endtask

    initial begin
        do_reset();

        // Best-case loop: one instruction every third cycle.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (i == 0) step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
                else if (i == 1) step(1'b0, 1'b1, 32'h0010_0093, 1'b1, 1'b0, 32'd0);
                else step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
                chk("t1_valid", {31'd0, inst_valid}, (i == 2) ? 32'd1 : 32'd0);
                if (i == 2) begin
                    chk("t1_pc", inst_pc, RST_PC + 32'(4 * k));
                    chk("t1_inst", inst, 32'h0010_0093);
                end
            end
        end

        // Decode stalls for 5 cycles.
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            chk("t2_valid", {31'd0, inst_valid}, 32'd1);
            chk("t2_inst", inst, 32'h1234_5678);
            chk("t2_pc", inst_pc, 32'h8000_000C);
            chk("t2_noreq", {31'd0, imem_req_valid}, 32'd0);
        end
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);

        // Redirect in WAIT kills the in-flight DEADBEEF response.
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_1000);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0);
        chk("t3_nvalid_a", {31'd0, inst_valid}, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("t3_nvalid_b", {31'd0, inst_valid}, 32'd0);
        chk("t3_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t3_addr", imem_addr, 32'h8000_1000);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("t3_inst", inst, 32'h0000_0013);
        chk("t3_pc", inst_pc, 32'h8000_1000);

        // Misaligned redirect target.
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0102);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("t4_mis", {31'd0, misalign_err}, 32'd1);
        chk("t4_addr", imem_addr, 32'h8000_0100);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
            chk("t4_sticky", {31'd0, misalign_err}, 32'd1);
        end

        // PC wraps from the top of the address space.
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("t5_pc", inst_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("t5_wrap", imem_addr, 32'h0000_0000);

        // Reset in WAIT, then a stale response arrives in S_REQ.
        step(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        do_reset();
        step(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("t6_nvalid", {31'd0, inst_valid}, 32'd0);
        chk("t6_req", {31'd0, imem_req_valid}, 32'd1);
        chk("t6_addr", imem_addr, RST_PC);
        step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("t6_pc", inst_pc, RST_PC);
        chk("t6_inst", inst, 32'hCAFE_0001);

        // Randomized traffic against the reference model.
        chk_data = 1'b1;
        pending  = 1'b0;
        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
